// File: rtl/riscv_pkg.sv
// Shared instruction-memory constants and the response owner tag used by the imem arbiter.
// BRAM geometry, window base and the NOP returned on faulting fetches live here.
package riscv_pkg;

   localparam int          IMEM_ADDR_BITS = 10;
   localparam logic [31:0] IMEM_BASE      = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_FETCH = 2'd1,
      OWN_LOAD  = 2'd2,
      OWN_FAULT = 2'd3
   } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: combinational grant, pointer flips only after a contested grant.
// req[0] has priority while the pointer is 0, req[1] while it is 1; nothing is granted during reset.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic r_ptr;

   always_comb begin
      gnt = 2'b00;
      if (!rst) begin
         if (req == 2'b11) begin
            gnt = r_ptr ? 2'b10 : 2'b01;
         end else begin
            gnt = req;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= 1'b0;
      end else if (req == 2'b11) begin
         r_ptr <= ~r_ptr;
      end
   end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction BRAM between fetch (read-only) and the loader (read/write).
// One BRAM access per cycle, 1-cycle response steered by a registered owner tag; bad fetches fault without a BRAM access.
module imem_port_arbiter
#(
   parameter int          ADDR_BITS = riscv_pkg::IMEM_ADDR_BITS,
   parameter logic [31:0] BASE_ADDR = riscv_pkg::IMEM_BASE,
   parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 f_req_valid,
   output logic                 f_req_ready,
   input  logic [31:0]          f_req_addr,
   input  logic                 f_flush,
   output logic                 f_rsp_valid,
   output logic [31:0]          f_rsp_data,
   output logic                 f_rsp_err,
   input  logic                 l_req_valid,
   output logic                 l_req_ready,
   input  logic                 l_req_we,
   input  logic [ADDR_BITS-1:0] l_req_addr,
   input  logic [31:0]          l_req_wdata,
   output logic                 l_rsp_valid,
   output logic [31:0]          l_rsp_data,
   output logic                 bram_en,
   output logic                 bram_we,
   output logic [ADDR_BITS-1:0] bram_addr,
   output logic [31:0]          bram_din,
   input  logic [31:0]          bram_dout
);

   import riscv_pkg::*;

   localparam logic [32:0] WIN_BYTES = 33'd4 << ADDR_BITS;

   logic [32:0] w_off;
   logic        w_in_range;
   logic        w_f_fault;
   logic [1:0]  w_req;
   logic [1:0]  w_gnt;
   logic        w_f_live;
   logic        w_l_live;
   owner_t      r_f_tag;
   owner_t      r_l_tag;

   // 33-bit subtract so addresses below the base wrap into bit 32 and fail the window check
   assign w_off      = {1'b0, f_req_addr} - {1'b0, BASE_ADDR};
   assign w_in_range = (f_req_addr[1:0] == 2'b00) && !w_off[32] && (w_off < WIN_BYTES);
   assign w_f_fault  = !rst && f_req_valid && !w_in_range;
   assign w_req      = {l_req_valid, f_req_valid & w_in_range};

   rr_arb2 u_arb (
      .clk (clk),
      .rst (rst),
      .req (w_req),
      .gnt (w_gnt)
   );

   always_comb begin
      f_req_ready = w_gnt[0] | w_f_fault;
      l_req_ready = w_gnt[1];
      bram_en     = |w_gnt;
      bram_we     = w_gnt[1] & l_req_we;
      bram_addr   = '0;
      bram_din    = '0;
      if (w_gnt[1]) begin
         bram_addr = l_req_addr;
         bram_din  = l_req_wdata;
      end else if (w_gnt[0]) begin
         bram_addr = w_off[ADDR_BITS+1:2];
      end
   end

   // Fetch and loader tags are separate: a fault and a loader read can both answer in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_f_tag <= OWN_NONE;
         r_l_tag <= OWN_NONE;
      end else begin
         r_f_tag <= w_f_fault ? OWN_FAULT : (w_gnt[0] ? OWN_FETCH : OWN_NONE);
         r_l_tag <= (w_gnt[1] && !l_req_we) ? OWN_LOAD : OWN_NONE;
      end
   end

   assign w_f_live = !rst && !f_flush && ((r_f_tag == OWN_FETCH) || (r_f_tag == OWN_FAULT));
   assign w_l_live = !rst && (r_l_tag == OWN_LOAD);

   always_comb begin
      f_rsp_valid = w_f_live;
      f_rsp_err   = 1'b0;
      f_rsp_data  = '0;
      if (w_f_live) begin
         f_rsp_err  = (r_f_tag == OWN_FAULT);
         f_rsp_data = (r_f_tag == OWN_FAULT) ? NOP_INSTR : bram_dout;
      end
      l_rsp_valid = w_l_live;
      l_rsp_data  = w_l_live ? bram_dout : '0;
   end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a read-first BRAM model; unwritten words read as 0xA0000000|index.
module tb_imem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        f_req_valid, f_req_ready, f_flush, f_rsp_valid, f_rsp_err;
   logic [31:0] f_req_addr, f_rsp_data;
   logic        l_req_valid, l_req_ready, l_req_we, l_rsp_valid;
   logic [9:0]  l_req_addr;
   logic [31:0] l_req_wdata, l_rsp_data;
   logic        bram_en, bram_we;
   logic [9:0]  bram_addr;
   logic [31:0] bram_din;
   logic [31:0] bram_dout = 32'h0;

   logic [31:0] mem     [0:1023];
   logic        written [0:1023];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   imem_port_arbiter dut (
      .clk(clk), .rst(rst),
      .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr),
      .f_flush(f_flush), .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data), .f_rsp_err(f_rsp_err),
      .l_req_valid(l_req_valid), .l_req_ready(l_req_ready), .l_req_we(l_req_we),
      .l_req_addr(l_req_addr), .l_req_wdata(l_req_wdata),
      .l_rsp_valid(l_rsp_valid), .l_rsp_data(l_rsp_data),
      .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
      .bram_dout(bram_dout)
   );

   // Read-first single-port BRAM
   always @(posedge clk) begin
      if (rst === 1'b1 && bram_en === 1'b1) begin
         n_checks <= n_checks + 1;
         $display("FAIL bram_en_in_reset: got 1 want 0");
      end
      if (bram_en === 1'b1) begin
         bram_dout <= (written[bram_addr] === 1'b1) ? mem[bram_addr] : (32'hA000_0000 | {22'h0, bram_addr});
         if (bram_we === 1'b1) begin
            mem[bram_addr]     <= bram_din;
            written[bram_addr] <= 1'b1;
         end
      end
   end

   task automatic drive(input logic fv, input logic [31:0] fa, input logic ff,
                        input logic lv, input logic lwe, input logic [9:0] la, input logic [31:0] lwd);
      f_req_valid = fv; f_req_addr = fa; f_flush = ff;
      l_req_valid = lv; l_req_we = lwe; l_req_addr = la; l_req_wdata = lwd;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 10'd0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if ({bram_en, f_req_ready, l_req_ready, f_rsp_valid, l_rsp_valid} !== 5'b0)
            $display("FAIL reset_outputs cycle %0d: got %b want 00000", i,
                     {bram_en, f_req_ready, l_req_ready, f_rsp_valid, l_rsp_valid});
         else n_pass++;
         next_cycle();
      end
      rst = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0);
      @(negedge clk);
      n_checks++;
      if ({bram_en, f_rsp_valid, l_rsp_valid} !== 3'b0)
         $display("FAIL reset_release_idle: got %b want 000", {bram_en, f_rsp_valid, l_rsp_valid});
      else n_pass++;
      next_cycle();
   endtask

   task automatic test_fetch_stream();
      logic [31:0] exp_rsp [0:2];
      exp_rsp[0] = 32'hA000_0000; exp_rsp[1] = 32'hA000_0001; exp_rsp[2] = 32'hA000_0002;
      for (int i = 0; i < 4; i++) begin
         if (i < 3) drive(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b0, 10'd0, 32'h0);
         else       drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0);
         @(negedge clk);
         if (i < 3) begin
            n_checks++;
            if ({f_req_ready, bram_en, bram_we, bram_addr} !== {3'b110, 10'(i)})
               $display("FAIL stream_grant %0d: got %b want %b", i,
                        {f_req_ready, bram_en, bram_we, bram_addr}, {3'b110, 10'(i)});
            else n_pass++;
         end
         if (i > 0) begin
            n_checks++;
            if ({f_rsp_valid, f_rsp_err, f_rsp_data} !== {2'b10, exp_rsp[i-1]})
               $display("FAIL stream_rsp %0d: got v%b e%b %h want v1 e0 %h", i,
                        f_rsp_valid, f_rsp_err, f_rsp_data, exp_rsp[i-1]);
            else n_pass++;
         end
         next_cycle();
      end
   endtask

   task automatic test_contention();
      // grants F,L,F,L; fetch word 4, loader word 7
      logic [1:0] exp_rdy [0:3];
      exp_rdy[0] = 2'b01; exp_rdy[1] = 2'b10; exp_rdy[2] = 2'b01; exp_rdy[3] = 2'b10;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) drive(1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 10'd7, 32'h0);
         else       drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0);
         @(negedge clk);
         if (i < 4) begin
            n_checks++;
            if ({l_req_ready, f_req_ready} !== exp_rdy[i] ||
                bram_addr !== (exp_rdy[i][1] ? 10'd7 : 10'd4))
               $display("FAIL contention_grant %0d: got rdy %b addr %0d want rdy %b", i,
                        {l_req_ready, f_req_ready}, bram_addr, exp_rdy[i]);
            else n_pass++;
         end
         if (i > 0) begin
            n_checks++;
            if (exp_rdy[i-1] == 2'b01) begin
               if ({f_rsp_valid, l_rsp_valid, f_rsp_data} !== {2'b10, 32'hA000_0004})
                  $display("FAIL contention_rsp_f %0d: got fv%b lv%b %h want fv1 lv0 a0000004", i,
                           f_rsp_valid, l_rsp_valid, f_rsp_data);
               else n_pass++;
            end else begin
               if ({f_rsp_valid, l_rsp_valid, l_rsp_data} !== {2'b01, 32'hA000_0007})
                  $display("FAIL contention_rsp_l %0d: got fv%b lv%b %h want fv0 lv1 a0000007", i,
                           f_rsp_valid, l_rsp_valid, l_rsp_data);
               else n_pass++;
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_fault();
      drive(1'b1, 32'h2, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0);
      @(negedge clk);
      n_checks++;
      if ({f_req_ready, bram_en} !== 2'b10)
         $display("FAIL fault_misaligned_req: got rdy%b en%b want rdy1 en0", f_req_ready, bram_en);
      else n_pass++;
      next_cycle();

      drive(1'b1, 32'h1000, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0);
      @(negedge clk);
      n_checks++;
      if ({f_req_ready, bram_en} !== 2'b10)
         $display("FAIL fault_window_req: got rdy%b en%b want rdy1 en0", f_req_ready, bram_en);
      else n_pass++;
      n_checks++;
      if ({f_rsp_valid, f_rsp_err, f_rsp_data} !== {2'b11, 32'h0000_0013})
         $display("FAIL fault_misaligned_rsp: got v%b e%b %h want v1 e1 00000013", f_rsp_valid, f_rsp_err, f_rsp_data);
      else n_pass++;
      next_cycle();

      drive(1'b1, 32'h2, 1'b0, 1'b1, 1'b0, 10'd3, 32'h0);
      @(negedge clk);
      n_checks++;
      if ({f_req_ready, l_req_ready, bram_en, bram_addr} !== {3'b111, 10'd3})
         $display("FAIL fault_with_loader: got fr%b lr%b en%b addr%0d want 1 1 1 3",
                  f_req_ready, l_req_ready, bram_en, bram_addr);
      else n_pass++;
      n_checks++;
      if ({f_rsp_valid, f_rsp_err, f_rsp_data} !== {2'b11, 32'h0000_0013})
         $display("FAIL fault_window_rsp: got v%b e%b %h want v1 e1 00000013", f_rsp_valid, f_rsp_err, f_rsp_data);
      else n_pass++;
      next_cycle();

      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0);
      @(negedge clk);
      n_checks++;
      if ({f_rsp_valid, f_rsp_err, f_rsp_data, l_rsp_valid, l_rsp_data} !== {2'b11, 32'h13, 1'b1, 32'hA000_0003})
         $display("FAIL fault_dual_rsp: got f v%b e%b %h l v%b %h want f 1 1 00000013 l 1 a0000003",
                  f_rsp_valid, f_rsp_err, f_rsp_data, l_rsp_valid, l_rsp_data);
      else n_pass++;
      next_cycle();
   endtask

   task automatic test_write_then_fetch();
      // fetch wins the contested cycle and reads the old word 5
      drive(1'b1, 32'h14, 1'b0, 1'b1, 1'b1, 10'd5, 32'hDEAD_BEEF);
      @(negedge clk);
      n_checks++;
      if ({f_req_ready, l_req_ready, bram_we} !== 3'b100)
         $display("FAIL write_contend: got fr%b lr%b we%b want 1 0 0", f_req_ready, l_req_ready, bram_we);
      else n_pass++;
      next_cycle();

      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 10'd5, 32'hDEAD_BEEF);
      @(negedge clk);
      n_checks++;
      if ({l_req_ready, bram_en, bram_we, bram_addr, bram_din} !== {3'b111, 10'd5, 32'hDEAD_BEEF})
         $display("FAIL write_issue: got lr%b en%b we%b addr%0d din %h want 1 1 1 5 deadbeef",
                  l_req_ready, bram_en, bram_we, bram_addr, bram_din);
      else n_pass++;
      n_checks++;
      if ({f_rsp_valid, f_rsp_data} !== {1'b1, 32'hA000_0005})
         $display("FAIL write_old_data: got v%b %h want v1 a0000005", f_rsp_valid, f_rsp_data);
      else n_pass++;
      next_cycle();

      drive(1'b1, 32'h14, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0);
      @(negedge clk);
      n_checks++;
      if (l_rsp_valid !== 1'b0)
         $display("FAIL write_no_rsp: got %b want 0", l_rsp_valid);
      else n_pass++;
      next_cycle();

      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0);
      @(negedge clk);
      n_checks++;
      if ({f_rsp_valid, f_rsp_err, f_rsp_data} !== {2'b10, 32'hDEAD_BEEF})
         $display("FAIL write_new_data: got v%b e%b %h want v1 e0 deadbeef", f_rsp_valid, f_rsp_err, f_rsp_data);
      else n_pass++;
      next_cycle();
   endtask

   task automatic test_flush();
      drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0);
      next_cycle();
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 10'd0, 32'h0);
      @(negedge clk);
      n_checks++;
      if (f_rsp_valid !== 1'b0)
         $display("FAIL flush_suppress: got %b want 0", f_rsp_valid);
      else n_pass++;
      next_cycle();

      drive(1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 10'd0, 32'h0);
      @(negedge clk);
      n_checks++;
      if (f_req_ready !== 1'b1)
         $display("FAIL flush_accept: got %b want 1", f_req_ready);
      else n_pass++;
      next_cycle();

      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0);
      @(negedge clk);
      n_checks++;
      if ({f_rsp_valid, f_rsp_data} !== {1'b1, 32'hA000_0001})
         $display("FAIL flush_delivered: got v%b %h want v1 a0000001", f_rsp_valid, f_rsp_data);
      else n_pass++;
      next_cycle();
   endtask

   task automatic test_reset_midflight();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 10'd2, 32'h0);
      @(negedge clk);
      n_checks++;
      if (l_req_ready !== 1'b1)
         $display("FAIL midrst_grant: got %b want 1", l_req_ready);
      else n_pass++;
      next_cycle();

      rst = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0);
      @(negedge clk);
      n_checks++;
      if (l_rsp_valid !== 1'b0)
         $display("FAIL midrst_rsp_dropped: got %b want 0", l_rsp_valid);
      else n_pass++;
      next_cycle();

      rst = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 10'd2, 32'h0);
      @(negedge clk);
      n_checks++;
      if ({l_rsp_valid, l_req_ready} !== 2'b01)
         $display("FAIL midrst_after: got lv%b lr%b want lv0 lr1", l_rsp_valid, l_req_ready);
      else n_pass++;
      next_cycle();

      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0);
      @(negedge clk);
      n_checks++;
      if ({l_rsp_valid, l_rsp_data} !== {1'b1, 32'hA000_0002})
         $display("FAIL midrst_recover: got v%b %h want v1 a0000002", l_rsp_valid, l_rsp_data);
      else n_pass++;
      next_cycle();
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         written[i] = 1'b0;
         mem[i]     = 32'h0;
      end
      test_reset();
      test_fetch_stream();
      test_contention();
      test_fault();
      test_write_then_fetch();
      test_flush();
      test_reset_midflight();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
